// File: rtl/ffd_eval_driver.sv
// ffd_eval_driver: drives an evolved async D-FF cell through SETUP/RISE/HOLD/FALL phases and scores it against a rising-edge DFF.
module ffd_eval_driver #(
   parameter int NUM_VECTORS = 16,
   parameter int SETTLE_CYCLES = 4,
   parameter logic [7:0] LFSR_SEED = 8'h01
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   output logic [1:0] dut_in,
   input  logic       dut_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
   output logic [7:0] fail_vec,
   output logic [1:0] fail_phase
);
   typedef enum logic [2:0] {IDLE, SETUP, RISE, HOLD, FALL, DONE} state_t;
   localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
   localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0] LAST_VEC = 8'(NUM_VECTORS - 1);
   state_t state, ns;
   logic [7:0] lfsr, lfsr_n, vec, cnt, err_n;
   logic [1:0] sync, phase;
   logic last, miss, d_n;
   always_comb begin
      last = cnt == LAST_CNT;
      phase = (state == RISE) ? 2'd0 : (state == HOLD) ? 2'd1 : 2'd2;
      miss = last && (state == RISE || state == HOLD || state == FALL) && (sync[1] != lfsr[0]);
      err_n = err_count + 8'(miss && err_count != 8'hFF);
      lfsr_n = (state == IDLE) ? SEED : (state == FALL && last) ? {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]} : lfsr;
      d_n = lfsr_n[0];
      ns = state;
      case (state)
         IDLE:    ns = start ? SETUP : IDLE;
         SETUP:   ns = last ? RISE : SETUP;
         RISE:    ns = last ? HOLD : RISE;
         HOLD:    ns = last ? FALL : HOLD;
         FALL:    ns = last ? ((vec == LAST_VEC) ? DONE : SETUP) : FALL;
         default: ns = IDLE;
      endcase
      if (abort) ns = IDLE;
   end
   // dut_in is registered from the next state so the cell sees glitch-free edges
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sync <= 2'b00;
         lfsr <= SEED;
         vec <= 8'd0;
         cnt <= 8'd0;
         dut_in <= 2'b00;
         busy <= 1'b0;
         done <= 1'b0;
         pass <= 1'b0;
         err_count <= 8'd0;
         fail_vec <= 8'd0;
         fail_phase <= 2'd3;
      end else begin
         sync <= {sync[0], dut_out};
         state <= ns;
         lfsr <= lfsr_n;
         cnt <= (ns != state) ? 8'd0 : cnt + 8'd1;
         vec <= (state == IDLE) ? 8'd0 : (state == FALL && last) ? vec + 8'd1 : vec;
         dut_in <= (ns == SETUP) ? {d_n, 1'b0} : (ns == RISE) ? {d_n, 1'b1} :
                   (ns == HOLD) ? {~d_n, 1'b1} : (ns == FALL) ? {~d_n, 1'b0} : 2'b00;
         busy <= ns != IDLE;
         done <= ns == DONE;
         if (state == IDLE) begin
            if (ns == SETUP) begin
               err_count <= 8'd0;
               fail_phase <= 2'd3;
               pass <= 1'b0;
            end
         end else begin
            err_count <= err_n;
            if (miss && fail_phase == 2'd3) begin
               fail_vec <= vec;
               fail_phase <= phase;
            end
            if (ns == DONE) pass <= err_n == 8'd0;
            if (abort) pass <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_ffd_eval_driver.sv
// tb_ffd_eval_driver: directed runs of ffd_eval_driver against several behavioural cells, scored by a per-vector reference model.
module tb_ffd_eval_driver;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, start2 = 1'b0;
   logic [1:0] dut_in, dut_in2, fail_phase, fp2;
   logic dut_out, busy, done, pass, busy2, done2, pass2;
   logic [7:0] err_count, fail_vec, err2, fv2;
   logic ff_q = 1'b0, lat_q = 1'b0;
   int vectors = 0, miscompares = 0, mode = 0;
   always #5 clk = ~clk;
   always @(posedge dut_in[0]) ff_q <= dut_in[1];
   always_latch if (dut_in[0]) lat_q <= dut_in[1];
   assign dut_out = (mode == 0) ? ff_q : (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : lat_q;

   ffd_eval_driver #(.NUM_VECTORS(8), .SETTLE_CYCLES(4), .LFSR_SEED(8'h01)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_in(dut_in), .dut_out(dut_out),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_vec(fail_vec), .fail_phase(fail_phase));
   ffd_eval_driver #(.NUM_VECTORS(255), .SETTLE_CYCLES(4), .LFSR_SEED(8'h00)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .dut_in(dut_in2), .dut_out(1'b0),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_vec(fv2), .fail_phase(fp2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Per-vector scoring: expected cell output at each checked phase versus the DFF value d.
   function automatic void model(input int md, input int n, output int err, output int fv, output int fp, output logic [254:0] ds);
      logic [7:0] l;
      logic q;
      l = 8'h01; err = 0; fv = 0; fp = 3; ds = '0;
      for (int v = 0; v < n; v++) begin
         ds[v] = l[0];
         for (int p = 0; p < 3; p++) begin
            q = (md == 0) ? l[0] : (md == 1) ? 1'b0 : (md == 2) ? 1'b1 : ((p == 0) ? l[0] : ~l[0]);
            if (q !== l[0]) begin
               if (fp == 3) begin fv = v; fp = p; end
               err++;
            end
         end
         l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      end
      if (err > 255) err = 255;
   endfunction

   task automatic run_check(input int md, input bit hold);
      int cyc, nseen, e, fv, fp;
      logic [254:0] seen, ds;
      logic prev;
      prev = 1'b0; nseen = 0; seen = '0;
      mode = md; start = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      cyc = 1;
      chk("busy_run", busy, 1);
      while (!done && cyc < 6000) begin
         if (dut_in[0] && !prev) begin seen[nseen] = dut_in[1]; nseen++; end
         prev = dut_in[0];
         @(posedge clk); #1; cyc++;
      end
      start = 1'b0;
      model(md, 8, e, fv, fp, ds);
      chk("done_seen", done, 1);
      chk("latency", cyc, 129);
      chk("pass", pass, e == 0);
      chk("err_count", err_count, e);
      chk("fail_phase", fail_phase, fp);
      if (fp != 3) chk("fail_vec", fail_vec, fv);
      if (md == 0) begin
         chk("rises", nseen, 8);
         chk("d_seq", seen[7:0], ds[7:0]);
      end
      @(posedge clk); #1;
      chk("done_pulse", done, 0);
      chk("busy_end", busy, 0);
      chk("dut_in_idle", dut_in, 0);
   endtask

   initial begin
      int c, e, fv, fp, hits;
      logic [254:0] ds;
      #12;
      chk("rst_dut_in", dut_in, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err", err_count, 0);
      chk("rst_fvec", fail_vec, 0);
      chk("rst_fphase", fail_phase, 3);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_check(0, 1'b0);
      run_check(1, 1'b0);
      run_check(2, 1'b0);
      run_check(3, 1'b0);
      run_check(0, 1'b1);
      hits = 0;
      for (int i = 0; i < 20; i++) begin @(posedge clk); #1; hits += int'(busy); end
      chk("no_restart", hits, 0);
      // abort at cycle 40 of a stuck-at-0 run
      mode = 1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i < 40; i++) begin @(posedge clk); #1; end
      abort = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0;
      chk("abort_dut_in", dut_in, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_pass", pass, 0);
      chk("abort_err", err_count, 3);
      chk("abort_fphase", fail_phase, 0);
      hits = 0;
      for (int i = 0; i < 200; i++) begin @(posedge clk); #1; hits += int'(done) + int'(busy); end
      chk("abort_quiet", hits, 0);
      // asynchronous reset mid-run
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin @(posedge clk); #1; end
      chk("pre_rst_err", err_count, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_dut_in", dut_in, 0);
      chk("arst_busy", busy, 0);
      chk("arst_err", err_count, 0);
      chk("arst_fphase", fail_phase, 3);
      chk("arst_pass", pass, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      hits = 0;
      for (int i = 0; i < 150; i++) begin @(posedge clk); #1; hits += int'(done) + int'(busy); end
      chk("rst_quiet", hits, 0);
      run_check(0, 1'b0);
      // saturation on the 255-vector instance, zero seed replaced by 01
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      c = 1;
      while (!done2 && c < 6000) begin @(posedge clk); #1; c++; end
      model(1, 255, e, fv, fp, ds);
      chk("sat_latency", c, 4081);
      chk("sat_err", err2, e);
      chk("sat_fphase", fp2, fp);
      chk("sat_fvec", fv2, fv);
      chk("sat_pass", pass2, 0);
      @(posedge clk); #1;
      chk("sat_busy", busy2, 0);
      chk("sat_dut_in", dut_in2, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
